// File: rtl/level_pkg.sv
// Shared definitions for the bubble-level poll controller: FSM states,
// accelerometer register constants and the LED position helper.
package level_pkg;

  typedef enum logic [2:0] {
    INIT,
    INIT_WAIT,
    IDLE,
    READ,
    COLLECT,
    UPDATE,
    ERROR
  } state_e;

  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] POWER_MEASURE = 8'h08;
  localparam logic [7:0] REG_DATAX0    = 8'h32;

  // Centre LED plus the scaled sample, pinned to the ends of the bar.
  function automatic int led_index(input logic signed [15:0] avg, input int half, input int shift);
    logic signed [15:0] steps;
    int                 pos;
    steps = avg >>> shift;
    pos   = int'(steps);
    if (pos > half) begin
      pos = half;
    end else if (pos < -half) begin
      pos = -half;
    end
    return half + pos;
  endfunction

endpackage

// File: rtl/level_poll_ctrl_if.sv
// Command/status bundle between the level controller (master) and the
// I2C engine that executes its transactions (slave).
interface level_poll_ctrl_if;
  logic       i2c_write_o;
  logic       i2c_read_o;
  logic [7:0] i2c_slave_addr_o;
  logic [7:0] i2c_din_o;
  logic [7:0] i2c_command_byte_o;
  logic [7:0] i2c_num_bytes_o;
  logic       i2c_busy_i;
  logic       i2c_rxak_i;
  logic       i2c_arb_lost_i;
  logic       i2c_write_done_i;
  logic       i2c_data_out_valid_i;
  logic [7:0] i2c_data_out_i;

  modport master (
    output i2c_write_o, i2c_read_o, i2c_slave_addr_o, i2c_din_o,
           i2c_command_byte_o, i2c_num_bytes_o,
    input  i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_write_done_i,
           i2c_data_out_valid_i, i2c_data_out_i
  );

  modport slave (
    input  i2c_write_o, i2c_read_o, i2c_slave_addr_o, i2c_din_o,
           i2c_command_byte_o, i2c_num_bytes_o,
    output i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_write_done_i,
           i2c_data_out_valid_i, i2c_data_out_i
  );
endinterface

// File: rtl/level_iir.sv
// One accelerometer axis: assembles the little-endian raw sample and keeps
// the first-order IIR average of it.
module level_iir #(
  parameter int AVG_SHIFT = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               byte_we_i,
  input  logic               byte_hi_i,
  input  logic [7:0]         byte_i,
  input  logic               update_i,
  input  logic               load_i,
  output logic signed [15:0] avg_o,
  output logic signed [15:0] avg_next_o
);
  logic signed [15:0] raw_q;
  logic signed [15:0] avg_q;
  logic signed [16:0] diff;
  logic signed [16:0] step;

  // The step always lands between avg and raw, so the 16-bit truncation never wraps.
  always_comb begin
    diff = {raw_q[15], raw_q} - {avg_q[15], avg_q};
    step = diff >>> AVG_SHIFT;
    avg_next_o = load_i ? raw_q : 16'({avg_q[15], avg_q} + step);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      raw_q <= '0;
      avg_q <= '0;
    end else begin
      if (byte_we_i) begin
        if (byte_hi_i) begin
          raw_q[15:8] <= byte_i;
        end else begin
          raw_q[7:0] <= byte_i;
        end
      end
      if (update_i) begin
        avg_q <= avg_next_o;
      end
    end
  end

  assign avg_o = avg_q;

endmodule

// File: rtl/level_poll_ctrl.sv
// Bubble-level controller: powers up the accelerometer over I2C, polls its
// axes periodically, filters them and drives a one-hot LED bar.
module level_poll_ctrl
  import level_pkg::*;
#(
  parameter int         NUM_LEDS    = 9,
  parameter int         NUM_AXES    = 2,
  parameter int         AVG_SHIFT   = 2,
  parameter int         SCALE_SHIFT = 5,
  parameter logic [7:0] SLAVE_ADDR  = 8'hA6,
  parameter int         POLL_DIV    = 50000,
  parameter int         TIMEOUT     = 100000,
  parameter int         MAX_RETRY   = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [1:0]               axis_sel_i,
  level_poll_ctrl_if.master        i2c,
  output logic [16*NUM_AXES-1:0]   axis_o,
  output logic                     sample_valid_o,
  output logic                     error_led_o,
  output logic [NUM_LEDS-1:0]      led_o
);
  localparam int         PW        = $clog2(POLL_DIV + 1);
  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam int         RW        = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [2:0] LAST_BYTE = 3'(2 * NUM_AXES - 1);

  state_e              state_q;
  logic [PW-1:0]       poll_cnt_q;
  logic [TW-1:0]       tout_q;
  logic [RW-1:0]       retry_q;
  logic [2:0]          byte_cnt_q;
  logic                write_q;
  logic                read_q;
  logic [7:0]          cmd_q;
  logic [7:0]          din_q;
  logic [7:0]          nbytes_q;
  logic                err_q;
  logic                first_q;
  logic                valid_q;
  logic [NUM_LEDS-1:0] led_q;
  logic [NUM_LEDS-1:0] led_d;

  logic                poll_tick;
  logic                waiting;
  logic                fault;
  logic                capture;
  logic [NUM_AXES-1:0] byte_we;
  logic signed [15:0]  avg_w      [NUM_AXES];
  logic signed [15:0]  avg_next_w [NUM_AXES];
  logic signed [15:0]  sel_avg;
  int                  sel_idx;

  assign poll_tick = (poll_cnt_q == PW'(POLL_DIV - 1));

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      poll_cnt_q <= '0;
    end else if (poll_tick) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_q + 1'b1;
    end
  end

  assign waiting = (state_q == INIT_WAIT) || (state_q == COLLECT);
  assign fault   = waiting && (i2c.i2c_arb_lost_i
                               || (i2c.i2c_write_done_i && i2c.i2c_rxak_i)
                               || (tout_q == TW'(TIMEOUT - 1)));
  assign capture = (state_q == COLLECT) && i2c.i2c_data_out_valid_i;

  for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
    assign byte_we[gi] = capture && (byte_cnt_q[2:1] == 2'(gi));

    level_iir #(.AVG_SHIFT(AVG_SHIFT)) u_iir (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .byte_we_i  (byte_we[gi]),
      .byte_hi_i  (byte_cnt_q[0]),
      .byte_i     (i2c.i2c_data_out_i),
      .update_i   (state_q == UPDATE),
      .load_i     (first_q),
      .avg_o      (avg_w[gi]),
      .avg_next_o (avg_next_w[gi])
    );

    assign axis_o[16*gi +: 16] = avg_w[gi];
  end

  // The LED is computed from the value the filter is about to store, so it
  // changes on the same edge as axis_o.
  always_comb begin
    sel_idx = int'(axis_sel_i);
    if (sel_idx >= NUM_AXES) begin
      sel_idx = 0;
    end
    sel_avg = avg_next_w[0];
    for (int i = 1; i < NUM_AXES; i++) begin
      if (sel_idx == i) begin
        sel_avg = avg_next_w[i];
      end
    end
    led_d = NUM_LEDS'(1) << led_index(sel_avg, NUM_LEDS / 2, SCALE_SHIFT);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= INIT;
      tout_q     <= '0;
      retry_q    <= '0;
      byte_cnt_q <= '0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      cmd_q      <= '0;
      din_q      <= '0;
      nbytes_q   <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b1;
      valid_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      write_q <= 1'b0;
      read_q  <= 1'b0;
      valid_q <= 1'b0;
      if (fault) begin
        if (retry_q == RW'(MAX_RETRY)) begin
          state_q <= ERROR;
          retry_q <= '0;
          err_q   <= 1'b1;
          first_q <= 1'b1;
        end else begin
          retry_q <= retry_q + 1'b1;
          state_q <= (state_q == INIT_WAIT) ? INIT : READ;
        end
      end else begin
        case (state_q)
          INIT: begin
            if (!i2c.i2c_busy_i) begin
              write_q  <= 1'b1;
              cmd_q    <= REG_POWER_CTL;
              din_q    <= POWER_MEASURE;
              nbytes_q <= 8'd1;
              tout_q   <= '0;
              state_q  <= INIT_WAIT;
            end
          end
          INIT_WAIT: begin
            if (i2c.i2c_write_done_i) begin
              retry_q <= '0;
              state_q <= IDLE;
            end else begin
              tout_q <= tout_q + 1'b1;
            end
          end
          IDLE: begin
            if (poll_tick) begin
              state_q <= READ;
            end
          end
          READ: begin
            if (!i2c.i2c_busy_i) begin
              read_q     <= 1'b1;
              cmd_q      <= REG_DATAX0;
              nbytes_q   <= 8'(2 * NUM_AXES);
              byte_cnt_q <= '0;
              tout_q     <= '0;
              state_q    <= COLLECT;
            end
          end
          COLLECT: begin
            if (i2c.i2c_data_out_valid_i) begin
              tout_q     <= '0;
              byte_cnt_q <= byte_cnt_q + 1'b1;
              if (byte_cnt_q == LAST_BYTE) begin
                retry_q <= '0;
                state_q <= UPDATE;
              end
            end else begin
              tout_q <= tout_q + 1'b1;
            end
          end
          UPDATE: begin
            valid_q <= 1'b1;
            led_q   <= led_d;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            state_q <= IDLE;
          end
          ERROR: begin
            if (poll_tick) begin
              state_q <= INIT;
            end
          end
          default: state_q <= INIT;
        endcase
      end
    end
  end

  assign i2c.i2c_write_o        = write_q;
  assign i2c.i2c_read_o         = read_q;
  assign i2c.i2c_slave_addr_o   = SLAVE_ADDR;
  assign i2c.i2c_din_o          = din_q;
  assign i2c.i2c_command_byte_o = cmd_q;
  assign i2c.i2c_num_bytes_o    = nbytes_q;
  assign sample_valid_o         = valid_q;
  assign error_led_o            = err_q;
  assign led_o                  = led_q;

endmodule

// File: tb/tb_level_poll_ctrl.sv
// Self-checking bench for level_poll_ctrl: fixed vectors, random samples
// against an arithmetic reference, and retry/error/reset sequences.
module tb_level_poll_ctrl;
  localparam int NUM_LEDS    = 9;
  localparam int NUM_AXES    = 2;
  localparam int AVG_SHIFT   = 2;
  localparam int SCALE_SHIFT = 5;
  localparam int POLL_DIV    = 64;
  localparam int TIMEOUT     = 40;
  localparam int MAX_RETRY   = 3;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  axis_sel;
  logic [31:0] axis;
  logic        sample_valid;
  logic        error_led;
  logic [8:0]  led;

  level_poll_ctrl_if bus();

  level_poll_ctrl #(
    .NUM_LEDS(NUM_LEDS), .NUM_AXES(NUM_AXES), .AVG_SHIFT(AVG_SHIFT),
    .SCALE_SHIFT(SCALE_SHIFT), .SLAVE_ADDR(8'hA6), .POLL_DIV(POLL_DIV),
    .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .axis_sel_i(axis_sel), .i2c(bus),
    .axis_o(axis), .sample_valid_o(sample_valid), .error_led_o(error_led), .led_o(led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: integer averages per axis, floor-division IIR.
  int m_avg [2];
  bit m_first;

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic int s16(input logic [15:0] x);
    return x[15] ? int'(x) - 65536 : int'(x);
  endfunction

  task automatic model_reset();
    m_first  = 1'b1;
    m_avg[0] = 0;
    m_avg[1] = 0;
  endtask

  task automatic model_update(input logic [15:0] r0, input logic [15:0] r1);
    int raw [2];
    int v;
    raw[0] = s16(r0);
    raw[1] = s16(r1);
    for (int i = 0; i < 2; i++) begin
      if (m_first) begin
        m_avg[i] = raw[i];
      end else begin
        v = m_avg[i] + floor_div(raw[i] - m_avg[i], 1 << AVG_SHIFT);
        if (v > 32767) v -= 65536;
        else if (v < -32768) v += 65536;
        m_avg[i] = v;
      end
    end
    m_first = 1'b0;
  endtask

  function automatic logic [8:0] model_led(input int a);
    int p;
    logic [8:0] one;
    one = 9'd1;
    p = floor_div(a, 1 << SCALE_SHIFT);
    if (p > NUM_LEDS / 2) p = NUM_LEDS / 2;
    if (p < -(NUM_LEDS / 2)) p = -(NUM_LEDS / 2);
    return one << (NUM_LEDS / 2 + p);
  endfunction

  function automatic logic [31:0] model_axis();
    return {16'(m_avg[1]), 16'(m_avg[0])};
  endfunction

  function automatic logic [15:0] pick_raw();
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return 16'($urandom_range(0, 600)) - 16'd300;
  endfunction

  task automatic wait_pulse(input bit is_read, input int budget, output bit found);
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      @(negedge clk);
      if (is_read ? bus.i2c_read_o : bus.i2c_write_o) found = 1'b1;
    end
  endtask

  task automatic respond_write(input logic nack);
    bus.i2c_write_done_i = 1'b1;
    bus.i2c_rxak_i       = nack;
    @(negedge clk);
    bus.i2c_write_done_i = 1'b0;
    bus.i2c_rxak_i       = 1'b0;
  endtask

  task automatic send_bytes(input logic [15:0] r0, input logic [15:0] r1);
    logic [7:0] b [4];
    b[0] = r0[7:0]; b[1] = r0[15:8]; b[2] = r1[7:0]; b[3] = r1[15:8];
    for (int i = 0; i < 4; i++) begin
      bus.i2c_data_out_valid_i = 1'b1;
      bus.i2c_data_out_i       = b[i];
      @(negedge clk);
    end
    bus.i2c_data_out_valid_i = 1'b0;
    bus.i2c_data_out_i       = 8'h00;
    chk("valid_early", sample_valid, 1'b0);
    @(negedge clk);
    chk("valid_2cyc", sample_valid, 1'b1);
    model_update(r0, r1);
  endtask

  task automatic do_sample(input logic [15:0] r0, input logic [15:0] r1, input logic [1:0] sel);
    bit found;
    axis_sel = sel;
    wait_pulse(1'b1, POLL_DIV + 20, found);
    chk("read_seen", found, 1'b1);
    if (!found) return;
    chk("read_cmd", bus.i2c_command_byte_o, 8'h32);
    chk("read_nbytes", bus.i2c_num_bytes_o, 8'd4);
    send_bytes(r0, r1);
  endtask

  task automatic check_sample(input string tag);
    int ax;
    ax = (axis_sel < 2'd2) ? int'(axis_sel) : 0;
    chk({tag, "_axis"}, axis, model_axis());
    chk({tag, "_led"}, led, model_led(m_avg[ax]));
    chk({tag, "_err"}, error_led, 1'b0);
  endtask

  typedef struct {
    logic [15:0] raw0;
    logic [15:0] raw1;
    logic [1:0]  sel;
    logic [15:0] exp_avg0;
    logic [15:0] exp_avg1;
    logic [8:0]  exp_led;
  } vec_t;

  vec_t tbl [5];

  initial begin
    bit found;
    int n;
    int writes;
    int extra;
    logic [15:0] r0;
    logic [15:0] r1;

    tbl[0] = '{16'h0200, 16'hFFE0, 2'd0, 16'h0200, 16'hFFE0, 9'h100};
    tbl[1] = '{16'h0000, 16'hFFE0, 2'd1, 16'h0180, 16'hFFE0, 9'h008};
    tbl[2] = '{16'h0000, 16'h0000, 2'd3, 16'h0120, 16'hFFE8, 9'h100};
    tbl[3] = '{16'hF000, 16'h0100, 2'd1, 16'hFCD8, 16'h002E, 9'h020};
    tbl[4] = '{16'hF000, 16'h0100, 2'd0, 16'hF9A2, 16'h0062, 9'h001};

    bus.i2c_busy_i = 1'b0;
    bus.i2c_rxak_i = 1'b0;
    bus.i2c_arb_lost_i = 1'b0;
    bus.i2c_write_done_i = 1'b0;
    bus.i2c_data_out_valid_i = 1'b0;
    bus.i2c_data_out_i = 8'h00;
    axis_sel = 2'd0;
    reset_i = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_led", led, 9'h000);
    chk("rst_err", error_led, 1'b0);
    chk("rst_axis", axis, 32'h0);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_write", bus.i2c_write_o, 1'b0);
    chk("rst_read", bus.i2c_read_o, 1'b0);
    reset_i = 1'b1;

    wait_pulse(1'b0, 20, found);
    chk("init_write_seen", found, 1'b1);
    chk("init_cmd", bus.i2c_command_byte_o, 8'h2D);
    chk("init_din", bus.i2c_din_o, 8'h08);
    chk("init_addr", bus.i2c_slave_addr_o, 8'hA6);
    respond_write(1'b0);

    for (int i = 0; i < 5; i++) begin
      do_sample(tbl[i].raw0, tbl[i].raw1, tbl[i].sel);
      chk($sformatf("vec%0d_avg0", i), axis[15:0], tbl[i].exp_avg0);
      chk($sformatf("vec%0d_avg1", i), axis[31:16], tbl[i].exp_avg1);
      chk($sformatf("vec%0d_led", i), led, tbl[i].exp_led);
      chk($sformatf("vec%0d_err", i), error_led, 1'b0);
    end

    // Random samples, with stray bytes thrown at the block while it is idle.
    for (int k = 0; k < 20; k++) begin
      r0 = pick_raw();
      r1 = pick_raw();
      repeat (2) begin
        bus.i2c_data_out_valid_i = 1'b1;
        bus.i2c_data_out_i = 8'($urandom);
        @(negedge clk);
      end
      bus.i2c_data_out_valid_i = 1'b0;
      do_sample(r0, r1, 2'($urandom_range(0, 3)));
      check_sample("rnd");
    end

    // Read with no bytes returned: expect a retried read after TIMEOUT.
    axis_sel = 2'd0;
    wait_pulse(1'b1, POLL_DIV + 20, found);
    chk("to_first_read", found, 1'b1);
    n = 0;
    found = 1'b0;
    while (!found && n < TIMEOUT + 20) begin
      @(negedge clk);
      n++;
      if (bus.i2c_read_o) found = 1'b1;
    end
    chk("to_retry_read", found, 1'b1);
    chk("to_retry_delay", (n >= TIMEOUT && n <= TIMEOUT + 3), 1'b1);
    send_bytes(16'h0123, 16'hFF00);
    check_sample("to");

    // Four NACKed init writes -> ERROR; recovery through a good sequence.
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    model_reset();
    writes = 0;
    for (int k = 0; k < 4; k++) begin
      wait_pulse(1'b0, 20, found);
      if (found) begin
        writes++;
        respond_write(1'b1);
      end
    end
    chk("err_write_pulses", writes, 4);
    chk("err_led_set", error_led, 1'b1);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.i2c_write_o) extra++;
    end
    chk("err_no_more_writes", extra, 0);
    wait_pulse(1'b0, POLL_DIV + 20, found);
    chk("err_reinit_write", found, 1'b1);
    chk("err_reinit_cmd", bus.i2c_command_byte_o, 8'h2D);
    respond_write(1'b0);
    chk("err_still_set", error_led, 1'b1);
    do_sample(16'h0040, 16'hFFC0, 2'd0);
    chk("err_cleared", error_led, 1'b0);
    chk("err_led_pos", led, 9'h040);
    chk("err_first_load", axis, 32'hFFC0_0040);

    // Reset asserted mid-COLLECT: outputs clear at once, no further pulses.
    wait_pulse(1'b1, POLL_DIV + 20, found);
    chk("mid_read_seen", found, 1'b1);
    bus.i2c_data_out_valid_i = 1'b1;
    bus.i2c_data_out_i = 8'h55;
    @(negedge clk);
    bus.i2c_data_out_valid_i = 1'b0;
    #2 reset_i = 1'b0;
    #1;
    chk("async_led", led, 9'h000);
    chk("async_axis", axis, 32'h0);
    chk("async_err", error_led, 1'b0);
    chk("async_valid", sample_valid, 1'b0);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.i2c_read_o || bus.i2c_write_o) extra++;
    end
    chk("async_no_pulses", extra, 0);
    reset_i = 1'b1;
    wait_pulse(1'b0, 10, found);
    chk("restart_write", found, 1'b1);
    chk("restart_cmd", bus.i2c_command_byte_o, 8'h2D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/level_poll_ctrl.md
LEVEL_POLL_CTRL -- requirements
Module: level_poll_ctrl

Interface
REQ-001 Parameter NUM_LEDS, default 9, bar length; SHALL be odd and at least 3.
REQ-002 Parameter NUM_AXES, default 2, axes read per poll, range 1..3.
REQ-003 Parameter AVG_SHIFT, default 2, IIR filter shift, range 0..4.
REQ-004 Parameter SCALE_SHIFT, default 5, raw-to-LED-step shift.
REQ-005 Parameter SLAVE_ADDR, default 8'hA6, I2C address byte.
REQ-006 Parameters POLL_DIV (default 50000) and TIMEOUT (default 100000), counted in clk_i cycles.
REQ-007 Parameter MAX_RETRY, default 3, retries before error.
REQ-008 clk_i  in  1  single clock; all logic on its rising edge.
REQ-009 reset_i  in  1  asynchronous, active-low reset.
REQ-010 axis_sel_i  in  2  axis driving led_o; values >= NUM_AXES select axis 0.
REQ-011 i2c_busy_i, i2c_rxak_i, i2c_arb_lost_i, i2c_write_done_i, i2c_data_out_valid_i  in  1 each  I2C master status.
REQ-012 i2c_data_out_i  in  8  read byte, valid when i2c_data_out_valid_i=1.
REQ-013 i2c_write_o, i2c_read_o  out  1 each  one-cycle transaction-start pulses.
REQ-014 i2c_slave_addr_o, i2c_din_o, i2c_command_byte_o, i2c_num_bytes_o  out  8 each  transaction fields.
REQ-015 axis_o  out  16*NUM_AXES  filtered signed samples, axis 0 in LSBs.
REQ-016 sample_valid_o  out  1  one-cycle pulse after every filter update.
REQ-017 error_led_o  out  1  sensor fault indicator.
REQ-018 led_o  out  NUM_LEDS  one-hot bubble position.

Function
REQ-019 States SHALL be INIT, INIT_WAIT, IDLE, READ, COLLECT, UPDATE, ERROR.
REQ-020 INIT SHALL pulse i2c_write_o once, with command 8'h2D and din 8'h08, only while i2c_busy_i=0; then go to INIT_WAIT.
REQ-021 INIT_WAIT SHALL go to IDLE on i2c_write_done_i with i2c_rxak_i=0.
REQ-022 IDLE SHALL go to READ on each poll tick; a free-running counter generates the tick every POLL_DIV cycles.
REQ-023 READ SHALL pulse i2c_read_o once (busy=0) with command 8'h32 and num_bytes 2*NUM_AXES, then go to COLLECT.
REQ-024 COLLECT SHALL capture bytes little-endian (low byte first) into per-axis raw registers and go to UPDATE after the last byte.
REQ-025 UPDATE SHALL apply avg <= avg + ((raw - avg) >>> AVG_SHIFT), using 17-bit signed arithmetic truncated to 16 bits.
REQ-026 The first UPDATE after reset or ERROR SHALL load avg <= raw directly.
REQ-027 UPDATE SHALL pulse sample_valid_o, update led_o, and return to IDLE; total latency from last byte to sample_valid_o is 2 cycles.
REQ-028 LED index SHALL be NUM_LEDS/2 + clamp(avg >>> SCALE_SHIFT, -(NUM_LEDS/2), +(NUM_LEDS/2)); led_o[index]=1 and all other bits 0.
REQ-029 A fault SHALL be i2c_rxak_i=1 at write_done, i2c_arb_lost_i=1, or TIMEOUT cycles elapsed in INIT_WAIT or COLLECT.
REQ-030 On a fault, the block SHALL increment the retry count and restart the failed transaction; after MAX_RETRY retries it SHALL enter ERROR.
REQ-031 ERROR SHALL set error_led_o=1 and hold led_o; on the next poll tick it SHALL go to INIT.
REQ-032 error_led_o SHALL clear on the first successful UPDATE.
REQ-033 The retry count SHALL clear on every successful transaction.
REQ-034 Bytes arriving outside COLLECT SHALL be ignored.
REQ-035 A poll tick arriving while not in IDLE or ERROR SHALL be dropped, not queued.

Reset
REQ-036 While reset_i=0 the block SHALL hold state INIT and clear all counters, avg, and raw registers.
REQ-037 While reset_i=0: led_o=0, error_led_o=0, pulses=0, axis_o=0, and the first-sample flag set.
REQ-038 Assertion of reset_i mid-transaction SHALL abort immediately with no further pulses; after release the sequence restarts at INIT.

Structure
REQ-039 A shared package level_pkg SHALL hold the state enum, register constants (8'h2D, 8'h08, 8'h32), and the clamp/index function.
REQ-040 One sub-module, level_iir, SHALL implement the filter for a single axis and be instantiated NUM_AXES times.

Verification
REQ-041 Reset release -> one write pulse with command 2D/din 08; write_done with rxak=0 -> IDLE; first read after POLL_DIV cycles with num_bytes=4.
REQ-042 Bytes 00,02 (axis0=0x0200), defaults -> avg=0x0200; index 4+clamp(16)=8; led_o=9'h100; sample_valid_o pulses 2 cycles after the last byte.
REQ-043 Second sample of 0x0000 after 0x0200 -> avg=0x0180; led_o=9'h100. Sample 0xFFE0 (-32) on first load -> index 3; led_o=9'h008.
REQ-044 rxak=1 on four consecutive INIT writes -> 4 write pulses, then error_led_o=1; next successful read sequence clears it.
REQ-045 No data_out_valid for TIMEOUT cycles in COLLECT -> retry read; reset_i low mid-COLLECT -> outputs zero asynchronously, no read pulse.
REQ-046 axis_sel_i=3 with NUM_AXES=2 -> led_o follows axis 0.
